// File: rtl/fp_normalize_round.sv
// Post-adder normalize and round-to-nearest-even stage for single-precision add/sub.
// Left-normalizes one bit per cycle and packs the IEEE result with exception flags.
module fp_normalize_round #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAN_W+1:0]         mantissa_sum,
  input  logic                     result_sign,
  input  logic [EXP_W-1:0]         exp_in,
  input  logic [2:0]               grs_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     flag_overflow,
  output logic                     flag_underflow,
  output logic                     flag_inexact,
  output logic                     flag_zero
);

  localparam int unsigned DP_W    = MAN_W + 2;
  localparam int unsigned XE_W    = EXP_W + 2;
  localparam int unsigned RES_W   = EXP_W + MAN_W + 1;
  localparam int unsigned CNT_W   = $clog2(MAN_W + 1);
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

  typedef enum logic [2:0] {IDLE, PRE, NORM, ROUND, OUT} state_t;

  state_t            state;
  logic [DP_W-1:0]   mant;
  logic [XE_W-1:0]   exp_q;
  logic              g, r, s;
  logic              sign_q;
  logic [CNT_W-1:0]  cnt;

  logic              round_up_c;
  logic              inexact_c;
  logic [DP_W-1:0]   mant_inc_c;
  logic [DP_W-2:0]   mant_rnd_c;
  logic [XE_W-1:0]   exp_rnd_c;
  logic              overflow_c;
  logic [EXP_W-1:0]  field_c;
  logic [RES_W-1:0]  rnd_result_c;
  logic [DP_W-1:0]   norm_mant_c;
  logic [XE_W-1:0]   norm_exp_c;

  // Rounding and packing of the current normalized value
  always_comb begin
    round_up_c = g & (r | s | mant[0]);
    inexact_c  = g | r | s;
    mant_inc_c = mant + DP_W'(round_up_c);
    mant_rnd_c = mant_inc_c[DP_W-2:0];
    exp_rnd_c  = exp_q;
    if (mant_inc_c[DP_W-1]) begin
      mant_rnd_c = mant_inc_c[DP_W-1:1];
      exp_rnd_c  = exp_q + XE_W'(1);
    end
    overflow_c = (exp_rnd_c >= XE_W'(EXP_MAX));
    // A denormal keeps exp==1 internally but packs a zero exponent field
    field_c    = mant_rnd_c[MAN_W] ? exp_rnd_c[EXP_W-1:0] : '0;
    if (overflow_c)
      rnd_result_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      rnd_result_c = {sign_q, field_c, mant_rnd_c[MAN_W-1:0]};
  end

  // One-bit left shift pulling the guard bit into the LSB
  always_comb begin
    norm_mant_c = {mant[DP_W-2:0], g};
    norm_exp_c  = exp_q - XE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      result         <= '0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
      flag_zero      <= 1'b0;
      mant           <= '0;
      exp_q          <= '0;
      g              <= 1'b0;
      r              <= 1'b0;
      s              <= 1'b0;
      sign_q         <= 1'b0;
      cnt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mant     <= mantissa_sum;
            exp_q    <= XE_W'(exp_in);
            {g, r, s} <= grs_in;
            sign_q   <= result_sign;
            in_ready <= 1'b0;
            state    <= PRE;
          end
        end
        PRE: begin
          cnt <= '0;
          if (mant == '0 && {g, r, s} == 3'b000) begin
            result    <= {sign_q, (RES_W-1)'(0)};
            flag_zero <= 1'b1;
            state     <= OUT;
          end else if (mant[DP_W-1]) begin
            mant  <= mant >> 1;
            exp_q <= exp_q + XE_W'(1);
            g     <= mant[0];
            r     <= g;
            s     <= r | s;
            state <= ROUND;
          end else if (!mant[MAN_W] && exp_q > XE_W'(1)) begin
            state <= NORM;
          end else begin
            state <= ROUND;
          end
        end
        NORM: begin
          mant  <= norm_mant_c;
          g     <= r;
          r     <= 1'b0;
          exp_q <= norm_exp_c;
          cnt   <= cnt + CNT_W'(1);
          if (norm_mant_c[MAN_W] || norm_exp_c == XE_W'(1) || cnt == CNT_W'(MAN_W - 1))
            state <= ROUND;
        end
        ROUND: begin
          result         <= rnd_result_c;
          flag_overflow  <= overflow_c;
          flag_inexact   <= inexact_c | overflow_c;
          flag_underflow <= !overflow_c && field_c == '0 && inexact_c;
          flag_zero      <= !overflow_c && rnd_result_c[RES_W-2:0] == '0;
          out_valid      <= 1'b1;
          state          <= OUT;
        end
        OUT: begin
          // Zero results arrive here straight from PRE; out_valid follows a cycle later
          if (out_valid && out_ready) begin
            out_valid      <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
            flag_zero      <= 1'b0;
            in_ready       <= 1'b1;
            state          <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Post-adder stage of the FP add/sub datapath. Consumes the 25-bit mantissa sum and result sign from the mantissa add/sub stage, the pre-shift exponent, and the guard/round/sticky bits from alignment.
- Normalizes the sum iteratively, one left shift per cycle, and rounds to nearest-even.
- Packs an IEEE 754 single-precision result with exception flags behind a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width; the datapath is MAN_W+2 bits including the implicit bit and carry

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept an input
- mantissa_sum  in  25  unnormalized magnitude; bit 23 is the implicit-one position, bit 24 is the carry
- result_sign  in  1  sign from the add/sub stage
- exp_in  in  8  biased exponent of the larger operand; legal range 1..254 (specials are handled upstream)
- grs_in  in  3  {guard, round, sticky} from alignment
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  32  packed {sign, exp, fraction}
- flag_overflow  out  1  result overflowed to infinity
- flag_underflow  out  1  result is tiny (exponent field 0, nonzero) and inexact
- flag_inexact  out  1  any nonzero bit was discarded
- flag_zero  out  1  result magnitude is zero

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; result=0; all flags=0; internal registers cleared. Reset mid-operation aborts the operation with no output.
- FSM states: IDLE, PRE, NORM, ROUND, OUT.
- IDLE: in_ready=1. When in_valid&in_ready, capture all inputs, go to PRE. in_ready=0 in every other state.
- PRE:
  - If mantissa_sum==0 and grs==0: go to OUT with result={result_sign,31'b0} and flag_zero=1.
  - Else if mant[24]=1: shift right by 1, exp+1. New guard=mant[0], round=old guard, sticky=old round|old sticky. Go to ROUND.
  - Else if mant[23]=0 and exp>1: go to NORM.
  - Else go to ROUND.
- NORM, one cycle per shift:
  - {mant,g} <= {mant[23:0],g,r}; r<=0; sticky unchanged; exp<=exp-1.
  - Leave for ROUND when mant[23]=1 or exp==1.
  - At most 23 shifts.
  - A denormal result leaves with exp==1 and mant[23]=0.
- ROUND:
  - round_up = g & (r | s | mant[0]).
  - inexact = g|r|s.
  - mant <= mant + round_up.
  - If the increment carries into bit 24: shift right 1, exp+1.
  - Exponent field = exp if mant[23]=1, else 0. A denormal that rounds up into bit 23 becomes the minimum normal.
  - If exp ≥ 255 after the carry or PRE adjustment: result={sign,8'hFF,23'b0}, flag_overflow=1, flag_inexact=1.
  - flag_underflow = (field==0) & inexact.
  - Go to OUT.
- OUT: out_valid=1. result and flags are held stable until out_ready=1. On the out_valid&out_ready edge, go to IDLE; out_valid drops on the next cycle. No new input is accepted in the same cycle (throughput is one op per latency+1).
- Latency: out_valid rises 2+k rising edges after the accept edge, where k = number of NORM cycles (0..23). The zero case uses k=0 and skips ROUND, so its latency is 2. Backpressure holds indefinitely.
- Flags are valid only while out_valid=1 and are cleared on return to IDLE.

Test Plan:
- 1.0+1.0: mantissa_sum=0x1000000, exp_in=127, grs=000, sign 0 → result=0x40000000, all flags 0, out_valid 2 edges after accept.
- Full cancellation residue: mantissa_sum=0x000001, exp_in=127, grs=000 → 23 NORM cycles, result=0x34000000, out_valid at 25 edges.
- Round-to-even, tie with odd LSB: mantissa_sum=0x800001, exp_in=127, grs=100 → result=0x3F800002, inexact=1. Same input with mantissa 0x800000 → result=0x3F800000, inexact=1.
- Rounding carry plus overflow:
  - mantissa_sum=0xFFFFFF, exp_in=127, grs=110 → result=0x40000000, inexact=1.
  - mantissa_sum=0x1000000, exp_in=254 → result=0x7F800000, overflow=1, inexact=1.
- Zero and denormal:
  - mantissa_sum=0, grs=0 → result=0x00000000, zero=1.
  - mantissa_sum=0x000010, exp_in=2, grs=000 → result=0x00000020, underflow=0.
  - Same input with grs=001 → underflow=1, inexact=1.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles → result stable, in_ready=0.
  - Assert rst_n=0 during NORM → immediately out_valid=0, in_ready=1; the next op completes correctly.
